regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Integer register file plus writeback stage for the RV32I core. Produces the RD1/RD2 operands consumed by the ALU operand muxes.
- Accepts the writeback result selected by ResultSrc.
- Tracks one outstanding variable-latency load: marks its destination pending, raises Stall on hazards, and commits ReadData when the memory response arrives.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, register count; address width is clog2(NREGS).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding onto RD1/RD2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  5  read address, port 1.
- A2  in  5  read address, port 2.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- A3  in  5  destination register.
- RegWrite  in  1  current instruction writes A3.
- ResultSrc  in  2  result select: 00 ALUResult, 01 ReadData (load), 10 PCPlus4, 11 ImmExt.
- ALUResult, ReadData, PCPlus4, ImmExt  in  XLEN each  writeback candidates.
- MemValid  in  1  load data valid this cycle.
- Result  out  XLEN  selected writeback value (combinational).
- Stall  out  1  front-end must hold the current instruction.
- LoadBusy  out  1  a load is outstanding.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all registers = 0
  - state = IDLE, PendRd = 0
  - Stall = 0, LoadBusy = 0
  - RD1/RD2 read 0
- x0 always reads 0. Writes to x0 are discarded and never create a pending entry.
- Reads are combinational from the array. With BYPASS=1, an enabled write this cycle to a nonzero register equal to A1/A2 forwards the write data onto RD1/RD2.
- Result is the ResultSrc mux, independent of state.
- State IDLE:
  - RegWrite and ResultSrc != 01: write Result to A3 on the rising edge.
  - RegWrite, ResultSrc == 01, MemValid=1: write ReadData to A3 on the same edge; stay IDLE.
  - RegWrite, ResultSrc == 01, MemValid=0, A3 != 0: PendRd <= A3; go to WAIT_LOAD. No write.
  - MemValid without a load in IDLE: ignored.
- State WAIT_LOAD:
  - LoadBusy = 1.
  - RawHaz = (A1==PendRd or A2==PendRd), nonzero address.
  - Stall = RegWrite or (RawHaz and !MemValid).
  - While Stall=1, the incoming RegWrite is suppressed.
  - On MemValid: write ReadData to PendRd; return to IDLE.
  - In the MemValid cycle, BYPASS forwards ReadData to RD1/RD2 when A1/A2 == PendRd. That clears RawHaz, so Stall depends only on RegWrite (port conflict).
  - A stalled instruction is re-presented and proceeds in IDLE on the next cycle.
- Single write port: at most one array write per cycle.
- Load-response priority over the instruction write is fixed.
- Reset during WAIT_LOAD abandons the load. A late MemValid arriving after reset is ignored.
- Stall is combinational from state and inputs. There is no registered stall latency.

Decomposition:
- Shared package rv_pkg holds:
  - ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11
  - the wb_state_t enum {IDLE, WAIT_LOAD}
  - the XLEN constant
- One natural sub-module: result_mux, the combinational 4:1 ResultSrc select, which is reusable by the core top.
- Array, bypass and FSM stay in regfile_wb.

Test Plan:
- Reset, then RegWrite=1, A3=5, ResultSrc=00, ALUResult=32'hDEADBEEF. Next cycle A1=5 -> RD1=DEADBEEF. Same cycle with BYPASS=1 -> RD1=DEADBEEF before the edge.
- RegWrite=1, A3=0, ResultSrc=10, PCPlus4=32'h00000104 -> A1=0 reads 0; LoadBusy stays 0.
- Load with A3=7, MemValid=0 -> LoadBusy=1. Next cycle A2=7 -> Stall=1. Two cycles later MemValid=1, ReadData=32'h12345678 -> Stall=0, RD2=12345678 (bypass); x7 holds 12345678 after the edge; LoadBusy=0.
- In WAIT_LOAD (PendRd=7): non-hazard read A1=3 -> Stall=0. Then RegWrite=1, A3=9, ResultSrc=11, ImmExt=32'hBEEF0000 -> Stall=1 and x9 unchanged. After MemValid, re-presented write commits x9=BEEF0000.
- Load in IDLE with MemValid=1, A3=4, ReadData=32'hAAAAAAAA -> x4=AAAAAAAA next cycle; no WAIT_LOAD entry.
- Assert reset mid-WAIT_LOAD -> LoadBusy=0 and all registers 0 immediately. A following MemValid=1 with ReadData=32'hFFFFFFFF writes nothing; x7 reads 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: writeback result-select encodings, writeback FSM states, data width.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/result_mux.sv
// Combinational 4:1 writeback result select, shared between the writeback stage and the core top.
module result_mux
  import rv_pkg::*;
#(
  parameter int W = rv_pkg::XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] pc_plus4,
  input  logic [W-1:0] imm_ext,
  output logic [W-1:0] result
);

  always_comb begin
    result = alu_result;
    case (sel)
      RES_ALU: result = alu_result;
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      RES_IMM: result = imm_ext;
      default: result = alu_result;
    endcase
  end

endmodule

// File: rtl/regfile_wb.sv
// Integer register file with writeback stage; tracks one outstanding variable-latency load
// and stalls the front end on hazards against its destination or on write-port conflicts.
module regfile_wb
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   A3,
  input  logic            RegWrite,
  input  logic [1:0]      ResultSrc,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] ReadData,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            MemValid,
  output logic [XLEN-1:0] Result,
  output logic            Stall,
  output logic            LoadBusy
);

  logic [XLEN-1:0] regs [NREGS];

  wb_state_t       state, state_next;
  logic [AW-1:0]   pend_rd, pend_rd_next;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            raw_haz;

  result_mux #(.W(XLEN)) u_result_mux (
    .sel        (ResultSrc),
    .alu_result (ALUResult),
    .read_data  (ReadData),
    .pc_plus4   (PCPlus4),
    .imm_ext    (ImmExt),
    .result     (Result)
  );

  // Single write port: in WAIT_LOAD only the load response may write, so the
  // load always wins and any concurrent instruction write is stalled instead.
  always_comb begin
    state_next   = state;
    pend_rd_next = pend_rd;
    we           = 1'b0;
    waddr        = A3;
    wdata        = Result;
    raw_haz      = 1'b0;
    Stall        = 1'b0;
    LoadBusy     = 1'b0;

    case (state)
      IDLE: begin
        if (RegWrite && (A3 != '0)) begin
          if (ResultSrc != RES_MEM) begin
            we = 1'b1;
          end else if (MemValid) begin
            we    = 1'b1;
            wdata = ReadData;
          end else begin
            pend_rd_next = A3;
            state_next   = WAIT_LOAD;
          end
        end
      end

      WAIT_LOAD: begin
        LoadBusy = 1'b1;
        raw_haz  = ((A1 == pend_rd) && (A1 != '0)) || ((A2 == pend_rd) && (A2 != '0));
        Stall    = RegWrite || (raw_haz && !MemValid);
        if (MemValid) begin
          we         = 1'b1;
          waddr      = pend_rd;
          wdata      = ReadData;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Keep reset dominant on the read path too, so forwarding cannot leak data.
    if (reset) begin
      we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pend_rd <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state   <= state_next;
      pend_rd <= pend_rd_next;
      if (we) begin
        regs[waddr] <= wdata;
      end
    end
  end

  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rd_addr[0] = A1;
  assign rd_addr[1] = A2;
  assign RD1        = rd_data[0];
  assign RD2        = rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = '0;
        if (rd_addr[gi] != '0) begin
          if ((BYPASS != 0) && we && (waddr == rd_addr[gi])) begin
            rd_data[gi] = wdata;
          end else begin
            rd_data[gi] = regs[rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb.sv
// Scenario bench for regfile_wb: each task queues expected values as it drives stimulus,
// queues the observed DUT outputs as they are sampled, then compares the two queues in order.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] RD1, RD2;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [31:0] ALUResult, ReadData, PCPlus4, ImmExt;
  logic        MemValid;
  logic [31:0] Result;
  logic        Stall, LoadBusy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] v;
  } chk_t;

  chk_t exp_q[$];
  chk_t obs_q[$];

  regfile_wb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .A3        (A3),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUResult (ALUResult),
    .ReadData  (ReadData),
    .PCPlus4   (PCPlus4),
    .ImmExt    (ImmExt),
    .MemValid  (MemValid),
    .Result    (Result),
    .Stall     (Stall),
    .LoadBusy  (LoadBusy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    A1 = 5'd0; A2 = 5'd0; A3 = 5'd0;
    RegWrite = 1'b0; ResultSrc = 2'b00; MemValid = 1'b0;
    ALUResult = '0; ReadData = '0; PCPlus4 = '0; ImmExt = '0;
  endtask

  task automatic want(input string name, input logic [31:0] v);
    exp_q.push_back('{name, v});
  endtask

  task automatic seen(input string name, input logic [31:0] v);
    obs_q.push_back('{name, v});
  endtask

  task automatic test_reset();
    chk_t e, o;
    idle_inputs();
    reset = 1'b1;
    A1 = 5'd5; A2 = 5'd7;
    want("rst_stall", 32'd0); want("rst_busy", 32'd0);
    want("rst_rd1", 32'd0);   want("rst_rd2", 32'd0);
    #1;
    seen("rst_stall", {31'd0, Stall}); seen("rst_busy", {31'd0, LoadBusy});
    seen("rst_rd1", RD1);              seen("rst_rd2", RD2);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_alu_write();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd5; ResultSrc = 2'b00; ALUResult = 32'hDEADBEEF; A1 = 5'd5;
    want("alu_result", 32'hDEADBEEF); want("alu_bypass_rd1", 32'hDEADBEEF);
    #1;
    seen("alu_result", Result); seen("alu_bypass_rd1", RD1);
    @(negedge clk);
    idle_inputs();
    A1 = 5'd5;
    want("alu_stored_rd1", 32'hDEADBEEF);
    #1;
    seen("alu_stored_rd1", RD1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_x0();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd0; ResultSrc = 2'b10; PCPlus4 = 32'h00000104; A1 = 5'd0;
    want("x0_result_pc4", 32'h00000104); want("x0_bypass_rd1", 32'd0);
    #1;
    seen("x0_result_pc4", Result); seen("x0_bypass_rd1", RD1);
    @(negedge clk);
    idle_inputs();
    A1 = 5'd0;
    want("x0_stored_rd1", 32'd0); want("x0_busy", 32'd0);
    #1;
    seen("x0_stored_rd1", RD1); seen("x0_busy", {31'd0, LoadBusy});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_load_wait();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd7; ResultSrc = 2'b01; MemValid = 1'b0;
    want("ld_issue_stall", 32'd0);
    #1;
    seen("ld_issue_stall", {31'd0, Stall});
    @(negedge clk);
    idle_inputs();
    A2 = 5'd7;
    want("ld_wait_busy", 32'd1); want("ld_haz_stall", 32'd1);
    #1;
    seen("ld_wait_busy", {31'd0, LoadBusy}); seen("ld_haz_stall", {31'd0, Stall});
    @(negedge clk);
    want("ld_haz_stall2", 32'd1);
    #1;
    seen("ld_haz_stall2", {31'd0, Stall});
    @(negedge clk);
    MemValid = 1'b1; ReadData = 32'h12345678;
    want("ld_resp_stall", 32'd0); want("ld_resp_bypass_rd2", 32'h12345678);
    #1;
    seen("ld_resp_stall", {31'd0, Stall}); seen("ld_resp_bypass_rd2", RD2);
    @(negedge clk);
    idle_inputs();
    A2 = 5'd7;
    want("ld_stored_rd2", 32'h12345678); want("ld_done_busy", 32'd0);
    #1;
    seen("ld_stored_rd2", RD2); seen("ld_done_busy", {31'd0, LoadBusy});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_port_conflict();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd7; ResultSrc = 2'b01;
    @(negedge clk);
    idle_inputs();
    A1 = 5'd3;
    want("pc_nohaz_stall", 32'd0); want("pc_nohaz_busy", 32'd1);
    #1;
    seen("pc_nohaz_stall", {31'd0, Stall}); seen("pc_nohaz_busy", {31'd0, LoadBusy});
    @(negedge clk);
    RegWrite = 1'b1; A3 = 5'd9; ResultSrc = 2'b11; ImmExt = 32'hBEEF0000; A1 = 5'd9;
    want("pc_wr_stall", 32'd1); want("pc_wr_suppressed_rd1", 32'd0);
    #1;
    seen("pc_wr_stall", {31'd0, Stall}); seen("pc_wr_suppressed_rd1", RD1);
    @(negedge clk);
    MemValid = 1'b1; ReadData = 32'h55550000; A2 = 5'd7;
    want("pc_resp_stall", 32'd1); want("pc_resp_rd1", 32'd0); want("pc_resp_rd2", 32'h55550000);
    #1;
    seen("pc_resp_stall", {31'd0, Stall}); seen("pc_resp_rd1", RD1); seen("pc_resp_rd2", RD2);
    @(negedge clk);
    MemValid = 1'b0;
    want("pc_replay_stall", 32'd0); want("pc_replay_rd1", 32'hBEEF0000);
    #1;
    seen("pc_replay_stall", {31'd0, Stall}); seen("pc_replay_rd1", RD1);
    @(negedge clk);
    idle_inputs();
    A1 = 5'd9; A2 = 5'd7;
    want("pc_x9", 32'hBEEF0000); want("pc_x7", 32'h55550000); want("pc_busy", 32'd0);
    #1;
    seen("pc_x9", RD1); seen("pc_x7", RD2); seen("pc_busy", {31'd0, LoadBusy});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_load_hit();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd4; ResultSrc = 2'b01; MemValid = 1'b1; ReadData = 32'hAAAAAAAA;
    want("hit_stall", 32'd0); want("hit_result", 32'hAAAAAAAA);
    #1;
    seen("hit_stall", {31'd0, Stall}); seen("hit_result", Result);
    @(negedge clk);
    idle_inputs();
    A1 = 5'd4;
    want("hit_x4", 32'hAAAAAAAA); want("hit_busy", 32'd0);
    #1;
    seen("hit_x4", RD1); seen("hit_busy", {31'd0, LoadBusy});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  task automatic test_reset_mid_load();
    chk_t e, o;
    @(negedge clk);
    idle_inputs();
    RegWrite = 1'b1; A3 = 5'd7; ResultSrc = 2'b01;
    @(negedge clk);
    idle_inputs();
    A1 = 5'd7; A2 = 5'd5;
    want("rml_busy_before", 32'd1); want("rml_x5_before", 32'hDEADBEEF);
    #1;
    seen("rml_busy_before", {31'd0, LoadBusy}); seen("rml_x5_before", RD2);
    #1;
    reset = 1'b1;
    want("rml_busy", 32'd0); want("rml_stall", 32'd0);
    want("rml_x7", 32'd0);   want("rml_x5", 32'd0);
    #1;
    seen("rml_busy", {31'd0, LoadBusy}); seen("rml_stall", {31'd0, Stall});
    seen("rml_x7", RD1);                 seen("rml_x5", RD2);
    @(negedge clk);
    reset = 1'b0;
    MemValid = 1'b1; ReadData = 32'hFFFFFFFF;
    want("rml_late_rd1", 32'd0); want("rml_late_stall", 32'd0);
    #1;
    seen("rml_late_rd1", RD1); seen("rml_late_stall", {31'd0, Stall});
    @(negedge clk);
    MemValid = 1'b0;
    want("rml_after_x7", 32'd0); want("rml_after_busy", 32'd0);
    #1;
    seen("rml_after_x7", RD1); seen("rml_after_busy", {31'd0, LoadBusy});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.v !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o.v, e.v); end
      else $display("ok   %s = %h", e.name, o.v);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_x0();
    test_load_wait();
    test_port_conflict();
    test_load_hit();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
